// File: rtl/cache_ctrl_wb_if.sv
// Bus bundle for cache_ctrl_wb: CPU request/response, cache array and backing RAM.
// The controller takes the slave modport; its surroundings (CPU, cache, RAM) take master.
interface cache_ctrl_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              done;
  logic              error;
  logic              busy;

  logic              cache_hit;
  logic              cache_miss;
  logic              dirty_evicted;
  logic [ADDR_W-1:0] evicted_address;
  logic [DATA_W-1:0] cache_read_data;
  logic [ADDR_W-1:0] cache_address;
  logic [DATA_W-1:0] cache_write_data;
  logic              cache_read;
  logic              cache_write;
  logic              cache_fill;

  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;
  logic              ram_ready;

  modport slave (
    input  read_req, write_req, cpu_address, cpu_write_data,
           cache_hit, cache_miss, dirty_evicted, evicted_address, cache_read_data,
           ram_read_data, ram_ready,
    output cpu_read_data, done, error, busy,
           cache_address, cache_write_data, cache_read, cache_write, cache_fill,
           ram_req, ram_we, ram_address, ram_write_data
  );

  modport master (
    output read_req, write_req, cpu_address, cpu_write_data,
           cache_hit, cache_miss, dirty_evicted, evicted_address, cache_read_data,
           ram_read_data, ram_ready,
    input  cpu_read_data, done, error, busy,
           cache_address, cache_write_data, cache_read, cache_write, cache_fill,
           ram_req, ram_we, ram_address, ram_write_data
  );
endinterface

// File: rtl/cache_ctrl_wb.sv
// Single-word-line write-back cache controller: lookup, dirty write-back, refill with
// RAM timeout, cache update and a one-cycle done/error response. All outputs are registered state.
module cache_ctrl_wb #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_W   = 8,
  parameter int RAM_TIMEOUT = 200
) (
  input  logic           clk,
  input  logic           rst,
  cache_ctrl_wb_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_UPDATE,
    S_RESP
  } state_e;

  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(RAM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   victim_addr_q, victim_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   victim_data_q, victim_data_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                op_write_q, op_write_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    victim_addr_d = victim_addr_q;
    wdata_d       = wdata_q;
    victim_data_d = victim_data_q;
    fill_d        = fill_q;
    rdata_d       = rdata_q;
    op_write_d    = op_write_q;
    error_d       = error_q;
    busy_d        = busy_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.read_req && bus.write_req) begin
          error_d = 1'b1;
          state_d = S_RESP;
        end else if (bus.read_req || bus.write_req) begin
          addr_d     = bus.cpu_address;
          wdata_d    = bus.cpu_write_data;
          op_write_d = bus.write_req;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        // A simultaneous hit and miss is resolved as a hit.
        if (bus.cache_hit) begin
          if (op_write_q) begin
            state_d = S_UPDATE;
          end else begin
            rdata_d = bus.cache_read_data;
            state_d = S_RESP;
          end
        end else if (bus.cache_miss) begin
          if (bus.dirty_evicted) begin
            victim_addr_d = bus.evicted_address;
            victim_data_d = bus.cache_read_data;
            cnt_d         = '0;
            state_d       = S_WB;
          end else if (op_write_q) begin
            state_d = S_UPDATE;
          end else begin
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
      end

      S_WB: begin
        if (bus.ram_ready) begin
          cnt_d   = '0;
          state_d = op_write_q ? S_UPDATE : S_FILL;
        end else if (cnt_q == LAST_WAIT) begin
          error_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_FILL: begin
        if (bus.ram_ready) begin
          rdata_d = bus.ram_read_data;
          fill_d  = bus.ram_read_data;
          state_d = S_UPDATE;
        end else if (cnt_q == LAST_WAIT) begin
          error_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_UPDATE: state_d = S_RESP;

      S_RESP: begin
        busy_d  = 1'b0;
        error_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      victim_addr_q <= '0;
      wdata_q       <= '0;
      victim_data_q <= '0;
      fill_q        <= '0;
      rdata_q       <= '0;
      op_write_q    <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      victim_addr_q <= victim_addr_d;
      wdata_q       <= wdata_d;
      victim_data_q <= victim_data_d;
      fill_q        <= fill_d;
      rdata_q       <= rdata_d;
      op_write_q    <= op_write_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign bus.cpu_read_data    = rdata_q;
  assign bus.done             = (state_q == S_RESP);
  assign bus.error            = (state_q == S_RESP) && error_q;
  assign bus.busy             = busy_q;
  assign bus.cache_address    = addr_q;
  assign bus.cache_read       = (state_q == S_LOOKUP);
  assign bus.cache_write      = (state_q == S_UPDATE);
  assign bus.cache_fill       = (state_q == S_UPDATE) && !op_write_q;
  assign bus.cache_write_data = (state_q != S_UPDATE) ? '0 : (op_write_q ? wdata_q : fill_q);
  assign bus.ram_req          = (state_q == S_WB) || (state_q == S_FILL);
  assign bus.ram_we           = (state_q == S_WB);
  assign bus.ram_address      = (state_q == S_WB)   ? victim_addr_q :
                                (state_q == S_FILL) ? addr_q : '0;
  assign bus.ram_write_data   = (state_q == S_WB) ? victim_data_q : '0;

endmodule

// File: doc/cache_ctrl_wb.md
Name: cache_ctrl_wb

Overview:
- Parametrised next-generation single-word-line cache controller between CPU request port, cache tag/data array and backing RAM.
- Latches one CPU request, performs lookup, optional dirty write-back, refill (reads only), cache update, then a one-cycle done/error response.
- Adds over the previous controller:
  - configurable widths
  - full RAM req/ready handshake with separate write-back and refill phases
  - victim data forwarding
  - no-fetch-on-write-miss
  - RAM timeout with error reporting
  - busy status

Parameters:
- ADDR_W, 32, address width of CPU, cache and RAM ports
- DATA_W, 64, data word width; one word per cache line
- TIMEOUT_W, 8, width of RAM wait counter
- RAM_TIMEOUT, 200, max cycles waiting for ram_ready per RAM phase; must be less than 2**TIMEOUT_W

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- read_req  input  1  CPU read request, sampled in IDLE only
- write_req  input  1  CPU write request, sampled in IDLE only
- cpu_address  input  ADDR_W  request address
- cpu_write_data  input  DATA_W  write data
- cpu_read_data  output  DATA_W  read result, valid while done=1
- done  output  1  one-cycle completion pulse
- error  output  1  qualifies done: request aborted
- busy  output  1  high from accept until the cycle after done
- cache_hit  input  1  lookup hit, valid in LOOKUP
- cache_miss  input  1  lookup miss, valid in LOOKUP
- dirty_evicted  input  1  victim line dirty, valid with cache_miss
- evicted_address  input  ADDR_W  victim address, valid with cache_miss
- cache_read_data  input  DATA_W  hit data, or victim data on miss
- cache_address  output  ADDR_W  latched request address
- cache_write_data  output  DATA_W  data to write into cache
- cache_read  output  1  lookup strobe
- cache_write  output  1  cache write strobe
- cache_fill  output  1  with cache_write: install clean line (refill)
- ram_req  output  1  RAM request, held until ram_ready
- ram_we  output  1  1 = write-back, 0 = refill read
- ram_address  output  ADDR_W  RAM address
- ram_write_data  output  DATA_W  write-back data
- ram_read_data  input  DATA_W  refill data, valid with ram_ready
- ram_ready  input  1  RAM phase complete, one cycle

Behaviour:
- Outputs: all registered or decoded from state register only; no combinational path from any input to any output.
- Reset (rst=0, async):
  - state=IDLE, all outputs 0, latched address/data/op cleared, timeout counter 0.
  - Reset mid-operation abandons the request with no done pulse; ram_req drops immediately.
- States: IDLE, LOOKUP, WB, FILL, UPDATE, RESP.
- IDLE:
  - Exactly one of read_req/write_req high: latch address, write data and op; busy=1 next cycle; go to LOOKUP.
  - Both high: no accept; go to RESP with error=1.
- LOOKUP:
  - cache_read=1, cache_address=latched address; waits indefinitely for cache_hit or cache_miss.
  - Both asserted: treat as hit.
  - Read hit: capture cache_read_data into cpu_read_data; go to RESP.
  - Write hit: go to UPDATE (cache_fill=0).
  - Miss with dirty_evicted=1: capture evicted_address and cache_read_data as victim; go to WB.
  - Miss with dirty_evicted=0: read goes to FILL; write goes to UPDATE.
- WB:
  - ram_req=1, ram_we=1, ram_address=victim address, ram_write_data=victim data.
  - On ram_ready: read goes to FILL, write goes to UPDATE.
- FILL:
  - ram_req=1, ram_we=0, ram_address=latched address.
  - On ram_ready: capture ram_read_data into cpu_read_data and fill buffer; go to UPDATE.
- Timeout counter:
  - Cleared on entry to WB and to FILL; increments each cycle without ram_ready.
  - Reaching RAM_TIMEOUT: drop ram_req, go to RESP with error=1; cache untouched.
  - ram_ready in the same cycle as the timeout wins (no error).
- UPDATE (one cycle):
  - cache_write=1, cache_address=latched address.
  - Read: cache_write_data=fill data, cache_fill=1.
  - Write: cache_write_data=cpu write data, cache_fill=0 (cache marks line dirty).
- RESP (one cycle):
  - done=1, error as determined; go to IDLE.
  - busy falls the next cycle.
  - A request held high re-triggers from IDLE.
- cpu_read_data holds its last value between reads; writes leave it unchanged.
- Latency, request sampled at cycle 0, cache answers in first LOOKUP cycle, done in cycle:
  - read hit: 2
  - write hit: 3
  - clean read miss: 4 + RAM latency
  - dirty read miss: 5 + both RAM latencies
  - clean write miss: 3, no RAM traffic

Test Plan:
- Read hit: read_req at 0x0000_0040, hit with data 0xDEAD_BEEF_0000_0001 -> done at cycle 2, cpu_read_data=0xDEAD_BEEF_0000_0001, ram_req never high.
- Clean read miss: 0x100, RAM returns 0x1234 after 3 cycles -> one RAM read at 0x100; cache_write=cache_fill=1 with 0x1234; done, cpu_read_data=0x1234.
- Dirty write miss: 0x200, data 0xAA, victim 0x300 holding 0x55 -> RAM write (0x300, 0x55), no RAM read; cache_write of 0xAA with cache_fill=0; done, error=0.
- Dirty read miss: victim 0x80, RAM returns 0x77 -> write-back then refill, in that order, each held until its ram_ready; done with cpu_read_data=0x77.
- Timeout: RAM_TIMEOUT=4, ram_ready never asserted -> ram_req drops after 4 cycles; done=error=1; cache_write never asserted.
- Edge cases:
  - read_req and write_req high together -> done=error=1 with no cache or RAM activity.
  - rst=0 during FILL -> all outputs 0 immediately; next request completes normally.
